if_fetch_queue: RTL

- IF-stage fetch controller between the PC register and the ID stage.
- Issues instruction-memory reads at the current PC and captures the 1-cycle-latency read data.
- Buffers {inst, pc} pairs in a small queue and presents them to ID with a valid/ready handshake.
- Throttles the PC through pc_wr_en and discards wrong-path instructions on a branch flush.

---
 rtl/if_fetch_queue_pkg.sv | 11 +
 rtl/defines.sv | 4 +
 rtl/if_fetch_queue_fifo.sv | 55 +++++
 rtl/if_fetch_queue.sv | 80 ++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the IF-stage fetch queue.
package if_fetch_queue_pkg;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] FETCH_INVALID_WORD = 32'h0;

endpackage

// File: rtl/defines.sv
// Project-wide macros shared by the fetch path.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

// File: rtl/if_fetch_queue_fifo.sv
// Circular FIFO of {inst, pc} fetch entries; clear empties it in one edge.
module fetch_fifo
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [31:0]              push_inst,
   input  logic [31:0]              push_pc,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [31:0]              head_inst,
   output logic [31:0]              head_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

   fetch_entry_t         storage [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !clear && push) begin
         storage[wr_ptr] <= '{inst: push_inst, pc: push_pc};
      end
   end

   assign head_inst = storage[rd_ptr].inst;
   assign head_pc   = storage[rd_ptr].pc;

   no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && !clear && count == FULL_COUNT));

endmodule

// File: rtl/if_fetch_queue.sv
// IF-stage fetch controller: credit-based imem issue, one in-flight read, queue to ID.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = `MEM_ADDR_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         pc_in,
   output logic                pc_wr_en,
   input  logic                flush,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [31:0]         imem_rdata,
   output logic                id_valid,
   input  logic                id_ready,
   output logic [31:0]         id_inst,
   output logic [31:0]         id_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_COUNT = DEPTH[PTR_W:0];

   logic [PTR_W:0]   count;
   logic [PTR_W:0]   credit_used;
   logic [31:0]      head_inst;
   logic [31:0]      head_pc;
   logic             inflight_q;
   logic [31:0]      inflight_pc;
   logic             pop;
   logic             push;

   assign id_valid = rst && (count != '0);
   assign pop      = id_valid && id_ready && !flush;
   assign push     = inflight_q && !flush;

   // A slot is reserved for the outstanding read, so issuing never overflows the queue.
   assign credit_used = count + {{PTR_W{1'b0}}, inflight_q} - {{PTR_W{1'b0}}, pop};
   assign imem_req    = rst && !flush && (credit_used < DEPTH_COUNT);
   assign pc_wr_en    = rst && (imem_req || flush);
   assign imem_addr   = pc_in[ADDR_W-1:0];

   assign id_inst = id_valid ? head_inst : FETCH_INVALID_WORD;
   assign id_pc   = id_valid ? head_pc   : FETCH_INVALID_WORD;

   always_ff @(posedge clk) begin
      if (!rst) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_req;
      end
   end

   always_ff @(posedge clk) begin
      if (imem_req) begin
         inflight_pc <= pc_in;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (push),
      .push_inst (imem_rdata),
      .push_pc   (inflight_pc),
      .pop       (pop),
      .count     (count),
      .head_inst (head_inst),
      .head_pc   (head_pc)
   );

endmodule
